// File: rtl/noc_link_receiver.sv
// noc_link_receiver
//   Terminates a credit-based NoC link and re-emits the flits as an AXI-Stream
//   style master. Incoming flits land in a small first-word-fall-through FIFO.
//   Each pop returns one credit upstream, one cycle after the pop. A two-state
//   packet tracker watches popped flits and flags any body/tail flit whose
//   destination differs from the head flit of its packet.
//
// Ports
//   clk_noc, rst_noc_sync       clock, synchronous active-high reset
//   data_in/dest_in/is_tail_in  flit fields from the upstream router
//   send_in                     flit valid (no handshake; credits pace it)
//   credit_out                  one-cycle credit return pulse
//   m_tvalid/m_tready           stream handshake
//   m_tdata/m_tdest/m_tlast     stream payload (head FIFO entry)
//   pkt_count                   tail flits delivered, wraps
//   overflow_err, dest_err      sticky error flags
module noc_link_receiver #(
  parameter int FLIT_WIDTH   = 32,
  parameter int DEST_WIDTH   = 6,
  parameter int BUFFER_DEPTH = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk_noc,
  input  logic                  rst_noc_sync,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [FLIT_WIDTH-1:0] m_tdata,
  output logic [DEST_WIDTH-1:0] m_tdest,
  output logic                  m_tlast,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  overflow_err,
  output logic                  dest_err
);

  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUFFER_DEPTH + 1);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  tail;
  } flit_t;

  typedef enum logic {IDLE, IN_PKT} state_e;

  flit_t                 mem_q [BUFFER_DEPTH];
  flit_t                 mem_d [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  credit_q, credit_d;
  logic [CNT_WIDTH-1:0]  pkt_q, pkt_d;
  logic                  ovf_q, ovf_d;
  logic                  derr_q, derr_d;
  state_e                state_q, state_d;
  logic [DEST_WIDTH-1:0] head_dest_q, head_dest_d;

  logic  empty, full, pop, push;
  flit_t head;

  // Pointers wrap at BUFFER_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] nxt_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty = (occ_q == '0);
    full  = (occ_q == OCC_W'(BUFFER_DEPTH));
    head  = mem_q[rd_ptr_q];
    pop   = !empty && m_tready;
    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    push  = send_in && !rst_noc_sync && (!full || pop);

    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    credit_d    = pop;
    pkt_d       = pkt_q;
    ovf_d       = ovf_q;
    derr_d      = derr_q;
    state_d     = state_q;
    head_dest_d = head_dest_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{data: data_in, dest: dest_in, tail: is_tail_in};
      wr_ptr_d        = nxt_ptr(wr_ptr_q);
    end
    if (pop)
      rd_ptr_d = nxt_ptr(rd_ptr_q);

    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    if (send_in && full && !pop)
      ovf_d = 1'b1;

    // Packet tracker advances only on delivered flits.
    if (pop) begin
      if (head.tail)
        pkt_d = pkt_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (!head.tail) begin
            state_d     = IN_PKT;
            head_dest_d = head.dest;
          end
        end
        IN_PKT: begin
          if (head.dest != head_dest_q)
            derr_d = 1'b1;
          if (head.tail)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      credit_q    <= 1'b0;
      pkt_q       <= '0;
      ovf_q       <= 1'b0;
      derr_q      <= 1'b0;
      state_q     <= IDLE;
      head_dest_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      credit_q    <= credit_d;
      pkt_q       <= pkt_d;
      ovf_q       <= ovf_d;
      derr_q      <= derr_d;
      state_q     <= state_d;
      head_dest_q <= head_dest_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_noc) begin
    mem_q <= mem_d;
  end

  assign m_tvalid     = !empty;
  assign m_tdata      = head.data;
  assign m_tdest      = head.dest;
  assign m_tlast      = head.tail;
  assign credit_out   = credit_q;
  assign pkt_count    = pkt_q;
  assign overflow_err = ovf_q;
  assign dest_err     = derr_q;

endmodule

// File: tb/tb_noc_link_receiver.sv
module tb_noc_link_receiver;

  localparam int FW = 32;
  localparam int DW = 6;
  localparam int DEPTH = 2;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic [FW-1:0] din;
  logic [DW-1:0] dst;
  logic          tail, send, ready;
  logic          credit_out, m_tvalid, m_tlast, overflow_err, dest_err;
  logic [FW-1:0] m_tdata;
  logic [DW-1:0] m_tdest;
  logic [CW-1:0] pkt_count;

  noc_link_receiver #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk_noc(clk), .rst_noc_sync(rst), .data_in(din), .dest_in(dst),
    .is_tail_in(tail), .send_in(send), .credit_out(credit_out),
    .m_tvalid(m_tvalid), .m_tready(ready), .m_tdata(m_tdata),
    .m_tdest(m_tdest), .m_tlast(m_tlast), .pkt_count(pkt_count),
    .overflow_err(overflow_err), .dest_err(dest_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int credit_cnt = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [FW-1:0] d;
    logic [DW-1:0] de;
    logic          t;
  } ent_t;

  ent_t          q[$];
  bit            e_credit, e_ovf, e_derr, in_pkt;
  logic [CW-1:0] e_pkt;
  logic [DW-1:0] hd;

  always @(posedge clk) begin
    ent_t e;
    bit   popped, was_full;
    if (rst) begin
      q.delete();
      e_credit = 0; e_ovf = 0; e_derr = 0; in_pkt = 0; e_pkt = '0;
    end else begin
      was_full = (q.size() == DEPTH);
      popped   = (q.size() != 0) && ready;
      if (popped) begin
        e = q.pop_front();
        if (e.t) e_pkt = e_pkt + 1'b1;
        if (!in_pkt) begin
          if (!e.t) begin in_pkt = 1; hd = e.de; end
        end else begin
          if (e.de != hd) e_derr = 1;
          if (e.t) in_pkt = 0;
        end
      end
      e_credit = popped;
      if (send) begin
        if (!was_full || popped) q.push_back('{d: din, de: dst, t: tail});
        else e_ovf = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_tvalid", m_tvalid, q.size() != 0);
      if (q.size() != 0) begin
        chk("m_tdata", m_tdata, q[0].d);
        chk("m_tdest", m_tdest, q[0].de);
        chk("m_tlast", m_tlast, q[0].t);
      end
      chk("credit_out", credit_out, e_credit);
      chk("pkt_count", pkt_count, e_pkt);
      chk("overflow_err", overflow_err, e_ovf);
      chk("dest_err", dest_err, e_derr);
      if (credit_out === 1'b1) credit_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic s, input logic [FW-1:0] d, input logic [DW-1:0] de,
                     input logic t, input logic r);
    send = s; din = d; dst = de; tail = t; ready = r;
    tick();
  endtask

  task automatic do_reset();
    rst = 1; send = 0; ready = 0;
    tick();
    rst = 0;
  endtask

  initial begin
    int c0;
    logic [DW-1:0] rd;
    rst = 1; send = 0; ready = 0; din = '0; dst = '0; tail = 0;
    tick();
    rst = 0;
    chk_en = 1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_credit", credit_out, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_derr", dest_err, 0);

    // single flit
    put(1, 32'hA5A5A5A5, 6'h05, 1, 1);
    chk("sf_valid", m_tvalid, 1);
    chk("sf_data", m_tdata, 32'hA5A5A5A5);
    chk("sf_dest", m_tdest, 6'h05);
    chk("sf_last", m_tlast, 1);
    chk("sf_credit_pre", credit_out, 0);
    put(0, 0, 0, 0, 1);
    chk("sf_credit", credit_out, 1);
    chk("sf_pkt", pkt_count, 1);
    tick();
    chk("sf_credit_end", credit_out, 0);

    // backpressure / overflow
    do_reset();
    put(1, 32'h11111111, 6'h01, 0, 0);
    put(1, 32'h22222222, 6'h01, 1, 0);
    put(1, 32'h33333333, 6'h01, 1, 0);
    send = 0;
    chk("bp_ovf", overflow_err, 1);
    chk("bp_head", m_tdata, 32'h11111111);
    c0 = credit_cnt;
    ready = 1;
    repeat (4) tick();
    chk("bp_credits", credit_cnt - c0, 2);
    chk("bp_empty", m_tvalid, 0);

    // full with simultaneous push and pop
    do_reset();
    put(1, 32'h44444444, 6'h02, 1, 0);
    put(1, 32'h55555555, 6'h02, 1, 0);
    put(1, 32'h66666666, 6'h02, 1, 1);
    chk("fp_head", m_tdata, 32'h55555555);
    chk("fp_ovf", overflow_err, 0);
    chk("fp_credit", credit_out, 1);
    put(0, 0, 0, 0, 0);
    chk("fp_credit_end", credit_out, 0);
    chk("fp_still", m_tdata, 32'h55555555);
    ready = 1;
    repeat (3) tick();
    chk("fp_drained", m_tvalid, 0);

    // multi-flit packets
    do_reset();
    for (int i = 0; i < 4; i++) put(1, 32'h100 + i, 6'h12, i == 3, 1);
    chk("mf_pkt_mid", pkt_count, 0);
    put(0, 0, 0, 0, 1);
    chk("mf_pkt", pkt_count, 1);
    chk("mf_derr", dest_err, 0);
    for (int i = 0; i < 4; i++) put(1, 32'h200 + i, (i == 2) ? 6'h13 : 6'h12, i == 3, 1);
    send = 0;
    repeat (2) tick();
    chk("mf_pkt2", pkt_count, 2);
    chk("mf_derr2", dest_err, 1);

    // reset mid-packet
    do_reset();
    for (int i = 0; i < 3; i++) put(1, 32'h300 + i, 6'h2A, 0, 0);
    put(0, 0, 0, 0, 1);
    ready = 0; rst = 1;
    tick();
    rst = 0;
    chk("rm_valid", m_tvalid, 0);
    chk("rm_credit", credit_out, 0);
    chk("rm_pkt", pkt_count, 0);
    put(1, 32'hCAFE0001, 6'h15, 1, 1);
    put(0, 0, 0, 0, 1);
    tick();
    chk("rm_pkt1", pkt_count, 1);
    chk("rm_derr", dest_err, 0);

    // streaming
    do_reset();
    c0 = credit_cnt;
    for (int i = 0; i < 64; i++) put(1, 32'h1000 + i, 6'h07, (i % 8) == 7, 1);
    send = 0;
    repeat (3) tick();
    chk("st_credits", credit_cnt - c0, 64);
    chk("st_pkt", pkt_count, 8);
    chk("st_ovf", overflow_err, 0);
    chk("st_derr", dest_err, 0);

    // randomized traffic, model-checked every cycle
    do_reset();
    rd = 6'h09;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) rd = DW'($urandom_range(0, 63));
      put($urandom_range(0, 99) < 60, $urandom, rd, $urandom_range(0, 3) == 0,
          $urandom_range(0, 99) < 55);
    end
    rst = 0; send = 0; ready = 1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_link_receiver.md
NOC_LINK_RECEIVER -- requirements
Module: noc_link_receiver

Interface
REQ-001 The module SHALL have parameter FLIT_WIDTH, default 32: data flit width in bits.
REQ-002 The module SHALL have parameter DEST_WIDTH, default 6: destination field width in bits (tid concatenated with tdest).
REQ-003 The module SHALL have parameter BUFFER_DEPTH, default 2: flit buffer entries, legal range 1..16; it equals the sender's initial credit count.
REQ-004 The module SHALL have parameter CNT_WIDTH, default 16: width of the packet counter.
REQ-005 clk_noc  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_noc_sync  input  1  reset, synchronous, active-high.
REQ-007 data_in  input  FLIT_WIDTH  flit payload from the upstream router output port.
REQ-008 dest_in  input  DEST_WIDTH  flit destination.
REQ-009 is_tail_in  input  1  flit is the last flit of its packet.
REQ-010 send_in  input  1  flit valid; a flit is offered in every cycle where it is high.
REQ-011 credit_out  output  1  one-cycle pulse returning one buffer credit upstream.
REQ-012 m_tvalid  output  1  stream output valid.
REQ-013 m_tready  input  1  stream output ready.
REQ-014 m_tdata  output  FLIT_WIDTH  stream payload.
REQ-015 m_tdest  output  DEST_WIDTH  stream destination.
REQ-016 m_tlast  output  1  stream end of packet (is_tail of the flit).
REQ-017 pkt_count  output  CNT_WIDTH  number of tail flits delivered on the stream output.
REQ-018 overflow_err  output  1  sticky: a flit arrived while the buffer was full.
REQ-019 dest_err  output  1  sticky: a non-head flit's dest differed from its packet head's dest.

Function
REQ-020 Push: send_in=1 SHALL write {data_in, dest_in, is_tail_in} into a FIFO of BUFFER_DEPTH entries in the same cycle, unless the FIFO is full and no pop occurs in that cycle.
REQ-021 Pop: the handshake m_tvalid=1 and m_tready=1 SHALL remove the head entry; m_tvalid SHALL equal "FIFO not empty"; m_tdata/m_tdest/m_tlast SHALL show the head entry (first-word fall-through).
REQ-022 Latency: a flit pushed in cycle N SHALL appear with m_tvalid=1 in cycle N+1 when the FIFO was empty; no combinational path from send_in to m_tvalid.
REQ-023 Full with simultaneous push and pop: both SHALL occur; occupancy is unchanged and no error is raised.
REQ-024 Empty with simultaneous push and pop: no pop SHALL occur (m_tvalid=0); the push completes.
REQ-025 Overflow: send_in=1 while full with no pop SHALL drop the flit, leave the FIFO unchanged, and set overflow_err from the next cycle until reset.
REQ-026 Credit: each pop in cycle N SHALL produce exactly one credit_out=1 in cycle N+1 (registered); credit_out is otherwise 0; credits are never merged or lost.
REQ-027 Stream rule: once m_tvalid=1, the head entry and m_tvalid SHALL stay stable until the pop.
REQ-028 The packet FSM SHALL have states IDLE and IN_PKT and SHALL advance on pops only.
REQ-029 IDLE, pop with m_tlast=0 -> IN_PKT, latching m_tdest as head_dest; IDLE, pop with m_tlast=1 -> IDLE (single-flit packet).
REQ-030 IN_PKT, pop with m_tdest != head_dest -> set dest_err (sticky); IN_PKT, pop with m_tlast=1 -> IDLE.
REQ-031 pkt_count SHALL increment by 1 on every pop with m_tlast=1 and SHALL wrap modulo 2^CNT_WIDTH.

Reset
REQ-032 When rst_noc_sync=1 at a clock edge, the following SHALL hold from the next cycle: FIFO empty, m_tvalid=0, credit_out=0, pkt_count=0, overflow_err=0, dest_err=0, FSM=IDLE. Any credit that was pending SHALL be discarded.
REQ-033 While rst_noc_sync=1, pushes SHALL be ignored. Assertion during a packet SHALL discard all buffered flits with no credits returned; the upstream sender is reset by the same reset.
REQ-034 m_tdata, m_tdest and m_tlast SHALL be don't-care whenever m_tvalid=0.

Verification
REQ-035 Single flit: push data=0xA5A5A5A5, dest=0x05, tail=1 with m_tready=1 -> m_tvalid in the next cycle with the same values, credit_out pulse one cycle after the pop, pkt_count=1.
REQ-036 Backpressure: BUFFER_DEPTH=2, m_tready=0, push 2 flits then a third -> third flit dropped, overflow_err=1; m_tready=1 -> the first two flits delivered in order, exactly 2 credit pulses.
REQ-037 Full with push and pop in the same cycle: depth 2 full, send_in=1 and m_tready=1 -> occupancy stays 2, overflow_err=0, one credit pulse.
REQ-038 Multi-flit packet: 4 flits with dest=0x12 and tail on flit 4 -> pkt_count increments only after flit 4, dest_err=0; repeat with flit 3 dest=0x13 -> dest_err=1.
REQ-039 Reset mid-packet: 2 flits buffered and FSM=IN_PKT, rst_noc_sync=1 for 1 cycle -> m_tvalid=0, credit_out=0, pkt_count=0, FSM=IDLE; a following single-flit packet is delivered normally.
REQ-040 Streaming: send_in=1 every cycle for 64 flits with m_tready=1 -> all 64 flits delivered in order, 64 credit pulses, no errors.
